// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the output-stationary systolic array tile:
//   - default operand / accumulator widths
//   - controller state encoding
//   - c_tile flat-index helper (PE(i,j) -> slot number in the flattened tile)
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // Row-major slot of PE(i,j) inside the flattened accumulator tile.
  function automatic int c_idx(input int i, input int j, input int pey);
    return (i * pey) + j;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// One signed multiply-accumulate cell of the systolic grid.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   clr_i               synchronous clear of accumulator and pipeline state
//   a_i / a_valid_i     operand from the left neighbour (or left edge)
//   b_i / b_valid_i     operand from the upper neighbour (or top edge)
//   a_o / a_valid_o     registered operand forwarded to the right neighbour
//   b_o / b_valid_o     registered operand forwarded to the lower neighbour
//   acc_o               live accumulator
// -----------------------------------------------------------------------------
module systolic_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              b_valid_i,
  output logic [DATA_W-1:0] a_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] b_o,
  output logic              b_valid_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_v_q, a_v_d, b_v_q, b_v_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  // Operands are widened to full product width before multiplying so the
  // product is exact; the assignment to ACC_W then sign-extends it.
  logic signed [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;
  logic        [ACC_W-1:0]    prod_ext_s;

  assign a_ext_s    = (2*DATA_W)'($signed(a_i));
  assign b_ext_s    = (2*DATA_W)'($signed(b_i));
  assign prod_s     = a_ext_s * b_ext_s;
  assign prod_ext_s = ACC_W'(prod_s);

  // Next-state: clear wins over forwarding and accumulation.
  always_comb begin
    a_d   = a_i;
    a_v_d = a_valid_i;
    b_d   = b_i;
    b_v_d = b_valid_i;
    acc_d = acc_q;
    if (clr_i) begin
      a_d   = '0;
      a_v_d = 1'b0;
      b_d   = '0;
      b_v_d = 1'b0;
      acc_d = '0;
    end else if (a_valid_i && b_valid_i) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      a_v_q <= 1'b0;
      b_q   <= '0;
      b_v_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      a_v_q <= a_v_d;
      b_q   <= b_d;
      b_v_q <= b_v_d;
      acc_q <= acc_d;
    end
  end

  assign a_o       = a_q;
  assign a_valid_o = a_v_q;
  assign b_o       = b_q;
  assign b_valid_o = b_v_q;
  assign acc_o     = acc_q;

endmodule

// File: rtl/systolic_array_tile.sv
// -----------------------------------------------------------------------------
// systolic_array_tile
// Output-stationary PEX x PEY grid of signed MAC cells computing C = A*B over a
// K_len-deep reduction. A rows enter pre-skewed on the left edge, B columns
// pre-skewed on the top edge.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 one-cycle pulse: clear tile and begin a run
//   K_len                 reduction depth, sampled on start
//   a_in / a_in_valid     left-edge operands, row i at [i*DATA_W +: DATA_W]
//   b_in / b_in_valid     top-edge operands, column j at [j*DATA_W +: DATA_W]
//   busy                  run in progress
//   done                  tile complete, held until next start
//   c_tile                live accumulators, PE(i,j) at [(i*PEY+j)*ACC_W +: ACC_W]
// -----------------------------------------------------------------------------
module systolic_array_tile
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PEX    = 4,
  parameter int PEY    = 4,
  parameter int KLEN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KLEN_W-1:0]          K_len,
  input  logic [PEX*DATA_W-1:0]      a_in,
  input  logic [PEX-1:0]             a_in_valid,
  input  logic [PEY*DATA_W-1:0]      b_in,
  input  logic [PEY-1:0]             b_in_valid,
  output logic                       busy,
  output logic                       done,
  output logic [PEX*PEY*ACC_W-1:0]   c_tile
);

  // Wide enough for K_len + PEX + PEY - 2 without overflow.
  localparam int CNT_W = KLEN_W + $clog2(PEX + PEY) + 1;

  // Edge wiring: column index j carries the operand entering PE(i,j);
  // the extra column/row collects what falls off the far edge.
  logic [DATA_W-1:0] a_w   [PEX][PEY+1];
  logic              a_v_w [PEX][PEY+1];
  logic [DATA_W-1:0] b_w   [PEX+1][PEY];
  logic              b_v_w [PEX+1][PEY];

  for (genvar i = 0; i < PEX; i++) begin : g_row_edge
    assign a_w[i][0]   = a_in[i*DATA_W +: DATA_W];
    assign a_v_w[i][0] = a_in_valid[i];
    logic unused_row_s;
    assign unused_row_s = ^{a_w[i][PEY], a_v_w[i][PEY]};
  end

  for (genvar j = 0; j < PEY; j++) begin : g_col_edge
    assign b_w[0][j]   = b_in[j*DATA_W +: DATA_W];
    assign b_v_w[0][j] = b_in_valid[j];
    logic unused_col_s;
    assign unused_col_s = ^{b_w[PEX][j], b_v_w[PEX][j]};
  end

  for (genvar i = 0; i < PEX; i++) begin : g_row
    for (genvar j = 0; j < PEY; j++) begin : g_col
      localparam int IDX = c_idx(i, j, PEY);
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start),
        .a_i       (a_w[i][j]),
        .a_valid_i (a_v_w[i][j]),
        .b_i       (b_w[i][j]),
        .b_valid_i (b_v_w[i][j]),
        .a_o       (a_w[i][j+1]),
        .a_valid_o (a_v_w[i][j+1]),
        .b_o       (b_w[i+1][j]),
        .b_valid_o (b_v_w[i+1][j]),
        .acc_o     (c_tile[IDX*ACC_W +: ACC_W])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: counts edges after start; the last MAC term lands at edge N.
  // ---------------------------------------------------------------------------
  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] n_calc_s, cnt_inc_s;

  assign n_calc_s  = CNT_W'(K_len) + CNT_W'(PEX + PEY - 2);
  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Next-state: start restarts from any state, including mid-run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      n_d     = (n_calc_s == '0) ? CNT_W'(1) : n_calc_s;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s >= n_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_systolic_array_tile.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_tile
// Directed bench for a 2x2 tile: skewed operand feeding, hand-computed C tiles,
// done/busy timing, restart, mid-run reset and K_len = 0.
// -----------------------------------------------------------------------------
module tb_systolic_array_tile;

  localparam int DW = 16;
  localparam int AW = 48;
  localparam int PX = 2;
  localparam int PY = 2;
  localparam int KW = 16;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        K_len;
  logic [PX*DW-1:0]     a_in;
  logic [PX-1:0]        a_in_valid;
  logic [PY*DW-1:0]     b_in;
  logic [PY-1:0]        b_in_valid;
  logic                 busy;
  logic                 done;
  logic [PX*PY*AW-1:0]  c_tile;

  int passed;
  int total;

  int a_m [PX][3];
  int b_m [3][PY];
  int bmask;
  longint exp_c [PX*PY];

  systolic_array_tile #(
    .DATA_W (DW),
    .ACC_W  (AW),
    .PEX    (PX),
    .PEY    (PY),
    .KLEN_W (KW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .K_len      (K_len),
    .a_in       (a_in),
    .a_in_valid (a_in_valid),
    .b_in       (b_in),
    .b_in_valid (b_in_valid),
    .busy       (busy),
    .done       (done),
    .c_tile     (c_tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] expv);
    total++;
    assert (got === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(expv));
  endtask

  task automatic check_c(input string tag);
    for (int p = 0; p < PX*PY; p++) begin
      chk($sformatf("%s_c%0d", tag, p), c_tile[p*AW +: AW], AW'(exp_c[p]));
    end
  endtask

  task automatic set_exp(input longint e0, input longint e1, input longint e2, input longint e3);
    exp_c[0] = e0;
    exp_c[1] = e1;
    exp_c[2] = e2;
    exp_c[3] = e3;
  endtask

  task automatic load_basic();
    a_m[0][0] = 1;  a_m[0][1] = 2;  a_m[0][2] = 3;
    a_m[1][0] = 11; a_m[1][1] = 12; a_m[1][2] = 13;
    b_m[0][0] = 2;  b_m[0][1] = 3;
    b_m[1][0] = 12; b_m[1][1] = 13;
    b_m[2][0] = 22; b_m[2][1] = 23;
    bmask = 7;
  endtask

  task automatic load_fill(input int av, input int bv);
    for (int i = 0; i < PX; i++)
      for (int k = 0; k < 3; k++) a_m[i][k] = av;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < PY; j++) b_m[k][j] = bv;
    bmask = 7;
  endtask

  // Pulse start, then feed skewed operands; stop_at >= 0 abandons the run
  // before feeding stimulus cycle stop_at.
  task automatic run_tile(input string tag, input int k_len, input int stop_at);
    int n;
    int k;
    n = k_len + PX + PY - 2;
    if (n < 1) n = 1;
    start      = 1'b1;
    K_len      = KW'(k_len);
    a_in_valid = '0;
    b_in_valid = '0;
    a_in       = '0;
    b_in       = '0;
    tick();
    start = 1'b0;
    chk({tag, "_busy_E0"}, AW'(busy), AW'(1));
    chk({tag, "_done_E0"}, AW'(done), AW'(0));
    for (int t = 0; t < n; t++) begin
      if (t == stop_at) begin
        a_in_valid = '0;
        b_in_valid = '0;
        return;
      end
      for (int i = 0; i < PX; i++) begin
        k = t - i;
        if (k >= 0 && k < k_len) begin
          a_in_valid[i]       = 1'b1;
          a_in[i*DW +: DW]    = DW'(a_m[i][k]);
        end else begin
          a_in_valid[i]       = 1'b0;
          a_in[i*DW +: DW]    = '0;
        end
      end
      for (int j = 0; j < PY; j++) begin
        k = t - j;
        if (k >= 0 && k < k_len && bmask[k]) begin
          b_in_valid[j]       = 1'b1;
          b_in[j*DW +: DW]    = DW'(b_m[k][j]);
        end else begin
          b_in_valid[j]       = 1'b0;
          b_in[j*DW +: DW]    = '0;
        end
      end
      tick();
      if (t == n - 2) begin
        chk({tag, "_done_before_last"}, AW'(done), AW'(0));
        chk({tag, "_busy_before_last"}, AW'(busy), AW'(1));
      end
    end
    a_in_valid = '0;
    b_in_valid = '0;
    chk({tag, "_done_at_EN"}, AW'(done), AW'(1));
    chk({tag, "_busy_at_EN"}, AW'(busy), AW'(0));
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    K_len      = '0;
    a_in       = '0;
    a_in_valid = '0;
    b_in       = '0;
    b_in_valid = '0;
    bmask      = 7;
    tick();
    tick();

    // Reset state
    set_exp(0, 0, 0, 0);
    check_c("reset");
    chk("reset_busy", AW'(busy), AW'(0));
    chk("reset_done", AW'(done), AW'(0));
    rst = 1'b1;
    tick();

    // Basic 2x2, K_len = 3; done at E5
    load_basic();
    run_tile("basic", 3, -1);
    set_exp(92, 98, 452, 488);
    check_c("basic");
    tick();
    tick();
    check_c("basic_hold");
    chk("basic_done_hold", AW'(done), AW'(1));

    // Signed extremes
    load_fill(-32768, -32768);
    run_tile("neg_neg", 1, -1);
    set_exp(1073741824, 1073741824, 1073741824, 1073741824);
    check_c("neg_neg");
    load_fill(32767, -32768);
    run_tile("pos_neg", 1, -1);
    set_exp(-1073709056, -1073709056, -1073709056, -1073709056);
    check_c("pos_neg");

    // Valid gap on k = 1
    load_basic();
    bmask = 5;
    run_tile("gap", 3, -1);
    set_exp(68, 72, 308, 332);
    check_c("gap");

    // Restart after done clears the prior tile
    load_fill(1, 1);
    run_tile("restart", 1, -1);
    set_exp(1, 1, 1, 1);
    check_c("restart");

    // Start mid-run
    load_basic();
    run_tile("midrun_a", 3, 3);
    load_fill(1, 1);
    run_tile("midrun_b", 1, -1);
    set_exp(1, 1, 1, 1);
    check_c("midrun");

    // Reset asserted at stimulus cycle 2 of a basic run
    load_basic();
    run_tile("rstmid", 3, 2);
    rst = 1'b0;
    #1;
    set_exp(0, 0, 0, 0);
    check_c("rstmid");
    chk("rstmid_busy", AW'(busy), AW'(0));
    chk("rstmid_done", AW'(done), AW'(0));
    tick();
    rst = 1'b1;
    tick();
    load_basic();
    run_tile("after_rst", 3, -1);
    set_exp(92, 98, 452, 488);
    check_c("after_rst");

    // K_len = 0: done at E2, empty tile
    load_basic();
    run_tile("klen0", 0, -1);
    set_exp(0, 0, 0, 0);
    check_c("klen0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_array_tile.md
# systolic_array_tile

Output-stationary PEX×PEY grid of signed multiply-accumulate processing elements that computes one C tile = A·B over a K_len-deep reduction. Sits between the tile scheduler, which supplies pre-skewed A rows on the left edge and B columns on the top edge, and the result writeback path, which reads the flattened accumulator tile once `done` is high.

## Interface
- DATA_W, 16, signed operand width
- ACC_W, 48, signed accumulator width; must be ≥ 2·DATA_W
- PEX, 4, rows (M dimension)
- PEY, 4, columns (N dimension)
- KLEN_W, 16, width of K_len
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear tile, begin run
- K_len  in  KLEN_W  reduction depth, sampled on start
- a_in  in  PEX·DATA_W  left-edge operand, row i at bits [i·DATA_W +: DATA_W]
- a_in_valid  in  PEX  per-row operand valid
- b_in  in  PEY·DATA_W  top-edge operand, column j at [j·DATA_W +: DATA_W]
- b_in_valid  in  PEY  per-column operand valid
- busy  out  1  run in progress
- done  out  1  tile complete, held until next start
- c_tile  out  PEX·PEY·ACC_W  accumulators, PE(i,j) at [(i·PEY+j)·ACC_W +: ACC_W]

## Operation
- PE(i,j): receives a from PE(i,j−1) (a_in[i] combinationally for j=0), b from PE(i−1,j) (b_in[j] for i=0).
- Each edge: PE registers a/a_valid to right neighbour, b/b_valid to lower neighbour; if a_valid && b_valid, acc += a·b.
- Product: signed DATA_W×DATA_W → 2·DATA_W, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
- Caller feeds skewed data: A[i][k] on row i at stimulus cycle k+i, B[k][j] on column j at cycle k+j; invalid slots drive valid=0 (data don't-care).
- Controller: IDLE → (start) RUN → (count reaches N) DONE → (start) RUN. N = K_len+PEX+PEY−2, minimum 1.
- start in any state (including RUN): clears all accumulators and pipeline valids, reloads K_len, restarts count; done drops.
- c_tile always reflects live accumulators; stable in DONE.

## Timing
- Reset: all acc, pipeline data/valids, counter = 0; busy=0, done=0, c_tile=0. Reset mid-run aborts; no partial result retained.
- E0 = edge sampling start. Stimulus cycle t lies before edge E(t+1).
- MAC term (i,j,k) lands at edge E(1+k+i+j); last term at E(N).
- busy high after E0 through E(N); done registered high at E(N), simultaneously with final acc update; busy low at same edge.
- Valids arriving outside RUN still propagate and accumulate (no gating); caller keeps valids low when idle.
- start and valid data in same cycle: clear takes priority; that cycle's edge data is discarded.

## Structure
- Package systolic_pkg: default DATA_W/ACC_W, controller state enum (IDLE, RUN, DONE), c_tile index helper function.
- Sub-module systolic_pe: one MAC cell (operand forwarding registers, valid forwarding, accumulator, synchronous clear input).
- Top: generate loops for PEX×PEY grid, edge wiring, controller counter.

## Test plan
- Basic 2×2, K_len=3: A rows {1,2,3},{11,12,13}; B rows {2,3},{12,13},{22,23}, skewed → C = 92, 98, 452, 488; done rises at E5, busy low after.
- Signed extremes, 2×2, K_len=1: all operands −32768 → every C = 1073741824; a=32767, b=−32768 → −1073709056.
- Valid gap: basic case with b_in_valid low for k=1 on both columns → C = 68, 72, 308, 332.
- Restart: after done, start with K_len=1, A all 1, B all 1 → all C = 1 (prior tile cleared); start mid-RUN also yields clean result.
- Reset mid-run: assert rst at stimulus cycle 2 → c_tile=0, busy=0, done=0 immediately; subsequent full run correct.
- K_len=0, 2×2: done at E2, all C = 0.
